fu_complete_buffer: RTL and testbench
=====================================

Name: fu_complete_buffer

Overview:
- Per-FU result holding stage directly upstream of complete_stage.
- Captures one result per functional unit (8 FU lanes), presents the valid mask as fu_finish, and packs up to 3 results into fu_c_in in completion priority order.
- Holds any result that complete_stage stalls via fu_c_stall, and back-pressures the owning FU until that result drains.
- Absorbs complete-hazard stalls so FUs never lose results.

Parameters:
- NUM_FU, 8, number of FU lanes; fixed by FU_STATE_PACKET width.
- NUM_CDB, 3, completion slots per cycle.
- XLEN, 32, result value width.
- PR_W, 6, physical register index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  synchronous flush on mispredict; clears all held results.
- fu_result_valid  in  NUM_FU  FU i presents a result this cycle.
- fu_result_pr  in  NUM_FU x PR_W  destination PR per FU; 0 = no writeback.
- fu_result_value  in  NUM_FU x XLEN  result value per FU.
- fu_ready  out  NUM_FU  FU i may present a result this cycle; the FU must hold its result while this is low.
- fu_finish  out  NUM_FU  FU_STATE_PACKET; slot i holds a valid result.
- fu_c_in  out  NUM_CDB x FU_COMPLETE_PACKET  packed results {dest_pr, dest_value}.
- fu_c_stall  in  NUM_FU  from complete_stage; slot i not accepted this cycle.

Behaviour:
- State per lane i:
  - slot_valid[i], slot_pr[i], slot_value[i].
  - Reset (reset==0, async) clears all slot_valid; pr/value reset to 0.
- Outputs:
  - fu_finish = slot_valid, purely registered.
  - In reset: fu_finish=0, fu_c_in all zero, fu_ready all 1.
- Priority: higher FU index wins (bit 7 highest), identical to complete_stage's selection.
  - fu_c_in[0] = highest-priority valid slot; fu_c_in[1] = next; fu_c_in[2] = third.
  - Unused entries are all-zero (dest_pr=0, dest_value=0).
- Drain: drained[i] = slot_valid[i] & ~fu_c_stall[i].
  - The bench checks that drained equals exactly the first min(3, popcount) slots in priority order.
- Ready: fu_ready[i] = ~slot_valid[i] | drained[i], combinational.
  - Same-cycle drain and refill of a lane is allowed; this gives full throughput of 1 result per FU per cycle.
- Capture at posedge, per lane:
  - squash: slot_valid <= 0 and all inputs are dropped, regardless of other signals.
  - fu_result_valid & fu_ready: load pr/value, slot_valid <= 1.
  - drained without a new result: slot_valid <= 0.
  - Otherwise: hold; a stalled slot keeps pr/value bit-exact.
- Latency: a result is visible on fu_c_in exactly 1 cycle after capture when there is no contention.
  - Worst case with all 8 lanes continuously valid: the lowest-priority lane waits indefinitely. Starvation is acceptable; FUs issue sparsely.
- Results with dest_pr==0 still occupy a completion slot; they are not filtered.
- fu_result_valid while fu_ready==0: the input is ignored; the FU protocol violation is flagged by assertion.
- Reset asserted mid-stall: all slots are lost immediately (asynchronous); no partial state survives.
- squash combined with a stall on the same cycle: the squash wins and the slot is cleared.

Decomposition:
- Shared package (existing sys_defs): FU_STATE_PACKET, FU_COMPLETE_PACKET, CDB_T_PACKET, `XLEN, PR index width, NUM_FU/NUM_CDB constants.
- One natural sub-module: fu_pack_sel.
  - Combinational; takes the valid mask and slot data.
  - Produces packed fu_c_in[2:0] using three cascaded ps8 selectors, mirroring complete_stage masking.
- The holding registers, ready logic and assertions stay in the top.

Test Plan:
- Reset/idle: hold reset low 2 cycles, release with no inputs -> fu_finish=0x00, fu_c_in all zero, fu_ready=0xFF.
- Single result: FU2 presents pr=5, value=0xDEADBEEF; complete_stage stall=0 -> next cycle fu_finish=0x04, fu_c_in[0]={5,0xDEADBEEF}, [1],[2] zero; cycle after, fu_finish=0x00.
- Contention: FUs 0,1,3,6 present in one cycle (pr=1,2,3,4) -> fu_finish=0x4B; fu_c_in = FU6, FU3, FU1; fu_c_stall=0x01; fu_ready[0]=0. Next cycle FU0 drains alone, with its value unchanged.
- Back-to-back refill: FU5 presents each cycle with pr=10,11,12, stall=0 -> fu_ready[5] stays 1, fu_c_in[0].dest_pr sequence 10,11,12 on consecutive cycles.
- Squash: 4 slots held, two of them stalled; assert squash for 1 cycle while FU4 presents -> next cycle fu_finish=0x00, FU4 result dropped.
- Async reset mid-stall: drop reset between clock edges while slots are valid -> fu_finish goes to 0 before the next edge; after release, fu_ready=0xFF.

Source files
------------

// File: rtl/fu_complete_buffer_pkg.sv
// Shared types for the FU result holding stage.
package fu_complete_buffer_pkg;
    localparam int NUM_FU  = 8;
    localparam int NUM_CDB = 3;
    localparam int XLEN    = 32;
    localparam int PR_W    = 6;

    typedef logic [NUM_FU-1:0] fu_state_packet_t;

    typedef struct packed {
        logic [PR_W-1:0] dest_pr;
        logic [XLEN-1:0] dest_value;
    } fu_complete_packet_t;

    // One-hot of the highest set bit (higher FU index wins).
    function automatic logic [NUM_FU-1:0] ps_hi(input logic [NUM_FU-1:0] req);
        ps_hi = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (req[i]) begin
                ps_hi    = '0;
                ps_hi[i] = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/fu_complete_buffer_if.sv
// FU-side and complete-side handshake bundle of the result holding stage.
interface fu_complete_buffer_if;
    import fu_complete_buffer_pkg::*;

    logic [NUM_FU-1:0]                   fu_result_valid;
    logic [NUM_FU-1:0][PR_W-1:0]         fu_result_pr;
    logic [NUM_FU-1:0][XLEN-1:0]         fu_result_value;
    logic [NUM_FU-1:0]                   fu_ready;
    fu_state_packet_t                    fu_finish;
    fu_complete_packet_t [NUM_CDB-1:0]   fu_c_in;
    logic [NUM_FU-1:0]                   fu_c_stall;

    modport master (
        output fu_result_valid, fu_result_pr, fu_result_value, fu_c_stall,
        input  fu_ready, fu_finish, fu_c_in
    );

    modport slave (
        input  fu_result_valid, fu_result_pr, fu_result_value, fu_c_stall,
        output fu_ready, fu_finish, fu_c_in
    );
endinterface

// File: rtl/fu_complete_buffer_pack_sel.sv
// Packs up to NUM_CDB held results into completion slots, highest FU index first.
module fu_pack_sel
    import fu_complete_buffer_pkg::*;
(
    input  logic [NUM_FU-1:0]                 valid,
    input  logic [NUM_FU-1:0][PR_W-1:0]       pr,
    input  logic [NUM_FU-1:0][XLEN-1:0]       value,
    output fu_complete_packet_t [NUM_CDB-1:0] c_in
);
    logic [NUM_CDB-1:0][NUM_FU-1:0] mask;
    logic [NUM_CDB-1:0][NUM_FU-1:0] sel;

    assign mask[0] = valid;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
        fu_complete_packet_t pkt;

        assign sel[k] = ps_hi(mask[k]);

        // Each stage sees only what earlier stages left behind.
        if (k < NUM_CDB - 1) begin : g_mask
            assign mask[k+1] = mask[k] & ~sel[k];
        end

        always_comb begin
            pkt = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (sel[k][i]) begin
                    pkt.dest_pr    = pr[i];
                    pkt.dest_value = value[i];
                end
            end
        end

        assign c_in[k] = pkt;
    end
endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU result holding stage in front of complete_stage; holds stalled results
// and back-pressures the owning FU until they drain.
module fu_complete_buffer
    import fu_complete_buffer_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    fu_complete_buffer_if.slave  bus
);
    logic [NUM_FU-1:0]           slot_valid;
    logic [NUM_FU-1:0][PR_W-1:0] slot_pr;
    logic [NUM_FU-1:0][XLEN-1:0] slot_value;
    logic [NUM_FU-1:0]           drained;
    logic [NUM_FU-1:0]           ready;

    assign drained = slot_valid & ~bus.fu_c_stall;
    // A lane draining this cycle may be refilled on the same edge.
    assign ready   = ~slot_valid | drained;

    assign bus.fu_ready  = ready;
    assign bus.fu_finish = slot_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid <= '0;
            slot_pr    <= '0;
            slot_value <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (squash) begin
                    slot_valid[i] <= 1'b0;
                end else if (bus.fu_result_valid[i] && ready[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_pr[i]    <= bus.fu_result_pr[i];
                    slot_value[i] <= bus.fu_result_value[i];
                end else if (drained[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    fu_pack_sel u_pack_sel (
        .valid (slot_valid),
        .pr    (slot_pr),
        .value (slot_value),
        .c_in  (bus.fu_c_in)
    );

    // An FU must keep its result internally while its ready is low.
    a_present_when_busy: assert property (
        @(posedge clock) disable iff (!reset)
        squash || ((bus.fu_result_valid & ~ready) == '0)
    );
endmodule

// File: tb/tb_fu_complete_buffer.sv
// Directed table, hand sequences and randomized scoreboard for fu_complete_buffer.
module tb_fu_complete_buffer;
    import fu_complete_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic squash = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fu_complete_buffer_if bus ();

    fu_complete_buffer dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         sq;
        logic [7:0]   vld;
        logic [7:0]   stall;
        logic [47:0]  pr;
        logic [7:0]   exf;
        logic [7:0]   exr;
        logic [5:0]   ep0, ep1, ep2;
        int           el0;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] vfun(input int lane, input logic [5:0] p);
        vfun = 32'hC0DE_0000 | (lane << 8) | {26'd0, p};
    endfunction

    function automatic vec_t mk(input logic sq, input logic [7:0] vld, input logic [7:0] stall,
                                input logic [47:0] pr, input logic [7:0] exf, input logic [7:0] exr,
                                input logic [5:0] ep0, input logic [5:0] ep1, input logic [5:0] ep2,
                                input int el0);
        vec_t v;
        v.sq = sq; v.vld = vld; v.stall = stall; v.pr = pr; v.exf = exf; v.exr = exr;
        v.ep0 = ep0; v.ep1 = ep1; v.ep2 = ep2; v.el0 = el0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.fu_result_valid = '0;
        bus.fu_result_pr    = '0;
        bus.fu_result_value = '0;
        bus.fu_c_stall      = '0;
        squash              = 1'b0;
    endtask

    // Scoreboard state for the random phase
    logic [7:0]       mv;
    logic [7:0][5:0]  mpr;
    logic [7:0][31:0] mval;

    initial begin
        logic [5:0]  p;
        logic [31:0] ev;
        logic [7:0]  sel;
        logic [7:0]  stall;
        logic [7:0]  vin;
        logic [7:0]  exr;
        logic [7:0]  nv;
        logic [7:0][5:0]  npr;
        logic [7:0][31:0] nval;
        fu_complete_packet_t ex[3];
        int k;

        drive_idle();

        //            sq  vld    stall  pr {7..0}                                                      exf    exr    ep0 ep1 ep2 el0
        tbl[0]  = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[1]  = mk(0, 8'h04, 8'h00, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd5,6'd0,6'd0},                    8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[2]  = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h04, 8'hFF, 5, 0, 0, 2);
        tbl[3]  = mk(0, 8'h4B, 8'h00, {6'd0,6'd4,6'd0,6'd0,6'd3,6'd0,6'd2,6'd1},                    8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[4]  = mk(0, 8'h00, 8'h01, 48'd0,                                                        8'h4B, 8'hFE, 4, 3, 2, 6);
        tbl[5]  = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h01, 8'hFF, 1, 0, 0, 0);
        tbl[6]  = mk(0, 8'h20, 8'h00, {6'd0,6'd0,6'd10,6'd0,6'd0,6'd0,6'd0,6'd0},                   8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[7]  = mk(0, 8'h20, 8'h00, {6'd0,6'd0,6'd11,6'd0,6'd0,6'd0,6'd0,6'd0},                   8'h20, 8'hFF, 10, 0, 0, 5);
        tbl[8]  = mk(0, 8'h20, 8'h00, {6'd0,6'd0,6'd12,6'd0,6'd0,6'd0,6'd0,6'd0},                   8'h20, 8'hFF, 11, 0, 0, 5);
        tbl[9]  = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h20, 8'hFF, 12, 0, 0, 5);
        tbl[10] = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[11] = mk(0, 8'h0F, 8'h00, {6'd0,6'd0,6'd0,6'd0,6'd4,6'd3,6'd2,6'd1},                    8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[12] = mk(0, 8'h00, 8'h0F, 48'd0,                                                        8'h0F, 8'hF0, 4, 3, 2, 3);
        tbl[13] = mk(1, 8'h10, 8'h09, {6'd0,6'd0,6'd0,6'd9,6'd0,6'd0,6'd0,6'd0},                    8'h0F, 8'hF6, 4, 3, 2, 3);
        tbl[14] = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[15] = mk(0, 8'h81, 8'h00, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd7},                    8'h00, 8'hFF, 0, 0, 0, -1);
        tbl[16] = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h81, 8'hFF, 0, 7, 0, 7);
        tbl[17] = mk(0, 8'h00, 8'h00, 48'd0,                                                        8'h00, 8'hFF, 0, 0, 0, -1);

        // Reset / idle
        repeat (2) @(negedge clock);
        chk("rst_finish", {56'd0, bus.fu_finish}, 64'h00);
        chk("rst_ready",  {56'd0, bus.fu_ready},  64'hFF);
        chk("rst_cin",    {50'd0, bus.fu_c_in[0] | bus.fu_c_in[1] | bus.fu_c_in[2]}, 64'd0);
        reset = 1'b1;

        foreach (tbl[s]) begin
            @(negedge clock);
            squash              = tbl[s].sq;
            bus.fu_c_stall      = tbl[s].stall;
            bus.fu_result_valid = tbl[s].vld;
            for (int l = 0; l < 8; l++) begin
                p = tbl[s].pr[l*6 +: 6];
                bus.fu_result_pr[l]    = p;
                bus.fu_result_value[l] = vfun(l, p);
            end
            #1;
            chk($sformatf("t%0d_finish", s), {56'd0, bus.fu_finish}, {56'd0, tbl[s].exf});
            chk($sformatf("t%0d_ready", s),  {56'd0, bus.fu_ready},  {56'd0, tbl[s].exr});
            chk($sformatf("t%0d_pr0", s), {58'd0, bus.fu_c_in[0].dest_pr}, {58'd0, tbl[s].ep0});
            chk($sformatf("t%0d_pr1", s), {58'd0, bus.fu_c_in[1].dest_pr}, {58'd0, tbl[s].ep1});
            chk($sformatf("t%0d_pr2", s), {58'd0, bus.fu_c_in[2].dest_pr}, {58'd0, tbl[s].ep2});
            ev = (tbl[s].el0 < 0) ? 32'd0 : vfun(tbl[s].el0, tbl[s].ep0);
            chk($sformatf("t%0d_val0", s), {32'd0, bus.fu_c_in[0].dest_value}, {32'd0, ev});
        end

        // Single result with a literal value
        @(negedge clock);
        drive_idle();
        bus.fu_result_valid[2] = 1'b1;
        bus.fu_result_pr[2]    = 6'd5;
        bus.fu_result_value[2] = 32'hDEADBEEF;
        @(negedge clock);
        drive_idle();
        #1;
        chk("single_finish", {56'd0, bus.fu_finish}, 64'h04);
        chk("single_cin0", {26'd0, bus.fu_c_in[0]}, {26'd0, 6'd5, 32'hDEADBEEF});
        chk("single_cin12", {26'd0, bus.fu_c_in[1] | bus.fu_c_in[2]}, 64'd0);
        @(negedge clock);
        #1;
        chk("single_gone", {56'd0, bus.fu_finish}, 64'h00);

        // Async reset while slots are stalled
        @(negedge clock);
        bus.fu_result_valid = 8'h03;
        bus.fu_result_pr    = '0;
        @(negedge clock);
        bus.fu_result_valid = 8'h00;
        bus.fu_c_stall      = 8'h03;
        #1;
        chk("ar_held", {56'd0, bus.fu_finish}, 64'h03);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_finish", {56'd0, bus.fu_finish}, 64'h00);
        chk("ar_cin", {50'd0, bus.fu_c_in[0] | bus.fu_c_in[1] | bus.fu_c_in[2]}, 64'd0);
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("ar_ready", {56'd0, bus.fu_ready}, 64'hFF);

        // Randomized run against the scoreboard
        mv = '0; mpr = '0; mval = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            // Expected completion slots: walk lanes from highest index down
            for (int j = 0; j < 3; j++) ex[j] = '0;
            sel = '0;
            k = 0;
            for (int i = 7; i >= 0; i--) begin
                if (mv[i] && k < 3) begin
                    ex[k].dest_pr    = mpr[i];
                    ex[k].dest_value = mval[i];
                    sel[i] = 1'b1;
                    k++;
                end
            end
            // complete_stage: unselected slots stall, selected ones occasionally hazard
            stall = '0;
            for (int i = 0; i < 8; i++) begin
                if (mv[i]) stall[i] = !sel[i] || ($urandom_range(3) == 0);
                else       stall[i] = $urandom_range(1);
            end
            exr = '0;
            for (int i = 0; i < 8; i++) exr[i] = !mv[i] || !stall[i];
            vin = '0;
            for (int i = 0; i < 8; i++) begin
                vin[i] = exr[i] && ($urandom_range(1) == 1);
                bus.fu_result_pr[i]    = 6'($urandom);
                bus.fu_result_value[i] = $urandom;
            end
            squash              = ($urandom_range(49) == 0);
            bus.fu_c_stall      = stall;
            bus.fu_result_valid = vin;
            #1;
            chk("rnd_finish", {56'd0, bus.fu_finish}, {56'd0, mv});
            chk("rnd_ready",  {56'd0, bus.fu_ready},  {56'd0, exr});
            for (int j = 0; j < 3; j++)
                chk($sformatf("rnd_cin%0d", j), {26'd0, bus.fu_c_in[j]}, {26'd0, ex[j]});
            nv = mv; npr = mpr; nval = mval;
            for (int i = 0; i < 8; i++) begin
                if (squash) nv[i] = 1'b0;
                else if (vin[i]) begin
                    nv[i] = 1'b1;
                    npr[i] = bus.fu_result_pr[i];
                    nval[i] = bus.fu_result_value[i];
                end else if (mv[i] && !stall[i]) nv[i] = 1'b0;
            end
            @(posedge clock);
            mv = nv; mpr = npr; mval = nval;
        end

        @(negedge clock);
        drive_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
